// File: rtl/da_pkg.sv
// Shared types and elaboration-time helpers for the distributed-arithmetic SOP engine.
package da_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Result width: one sample's worth of bit-plane weights on top of the entry width.
  function automatic int sop_width(input int b, input int l);
    return b + l;
  endfunction

endpackage

// File: rtl/da_lut.sv
// Runtime-writable 2^N-entry partial-sum table: synchronous write, asynchronous read, clears on reset.
module da_lut
  import da_pkg::*;
#(
  parameter int N = 4,
  parameter int L = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic [N-1:0] waddr,
  input  logic [L-1:0] wdata,
  input  logic [N-1:0] raddr,
  output logic [L-1:0] rdata
);

  localparam int DEPTH = 2 ** N;

  logic [L-1:0] entry_view [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [L-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          entry_reg <= '0;
        end else if (we && (waddr == N'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign entry_view[gi] = entry_reg;
    end
  endgenerate

  assign rdata = entry_view[raddr];

endmodule

// File: rtl/da_sop_engine.sv
// Bit-serial distributed-arithmetic sum-of-products: y = sum c_k*x_k, one bit-plane per cycle,
// LSB first, with the sign-bit plane subtracted for two's-complement samples.
module da_sop_engine
  import da_pkg::*;
#(
  parameter int N = 4,
  parameter int B = 8,
  parameter int L = 10,
  parameter int W = sop_width(B, L)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*B-1:0] x_in,
  input  logic           signed_mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           lut_we,
  input  logic [N-1:0]   lut_addr,
  input  logic [L-1:0]   lut_data,
  output logic           busy,
  output logic [W-1:0]   y,
  output logic           y_valid
);

  localparam int CW = (clog2(B) < 1) ? 1 : clog2(B);

  state_t                state_reg;
  logic [N-1:0][B-1:0]   shift_reg;
  logic signed [W-1:0]   acc_reg;
  logic signed [W-1:0]   acc_next;
  logic signed [W-1:0]   entry_ext;
  logic signed [W-1:0]   term;
  logic [CW-1:0]         cnt_reg;
  logic                  sign_reg;
  logic                  last_plane;
  logic                  table_we;
  logic [N-1:0]          rd_index;
  logic [L-1:0]          rd_data;

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  // The table must stay stable while bit-planes are being looked up.
  assign table_we = lut_we && (state_reg != SHIFT);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_index
      assign rd_index[gi] = shift_reg[gi][0];
    end
  endgenerate

  da_lut #(
    .N(N),
    .L(L)
  ) u_lut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (table_we),
    .waddr  (lut_addr),
    .wdata  (lut_data),
    .raddr  (rd_index),
    .rdata  (rd_data)
  );

  assign last_plane = (cnt_reg == CW'(B - 1));

  always_comb begin
    entry_ext = {{(W - L){rd_data[L-1]}}, rd_data};
    term      = entry_ext <<< (B - 1);
    // Sign-bit plane carries weight -2^(B-1) for two's-complement samples.
    acc_next  = (acc_reg >>> 1) + ((last_plane && sign_reg) ? -term : term);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
      y         <= '0;
      y_valid   <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N; k++) shift_reg[k] <= x_in[k*B +: B];
            sign_reg  <= signed_mode;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          for (int k = 0; k < N; k++) shift_reg[k] <= shift_reg[k] >> 1;
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_plane) begin
            // Strobe is registered here so it is high during the DONE cycle.
            y         <= acc_next;
            y_valid   <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_sop_engine.sv
// Randomised self-checking bench for da_sop_engine against a plain sum-of-products reference.
module tb_da_sop_engine;

  localparam int N = 4;
  localparam int B = 8;
  localparam int L = 10;
  localparam int W = B + L;

  logic           clk;
  logic           reset_n;
  logic [N*B-1:0] x_in;
  logic           signed_mode;
  logic           in_valid;
  logic           in_ready;
  logic           lut_we;
  logic [N-1:0]   lut_addr;
  logic [L-1:0]   lut_data;
  logic           busy;
  logic [W-1:0]   y;
  logic           y_valid;

  int n_checks = 0;
  int n_pass   = 0;

  da_sop_engine #(.N(N), .B(B), .L(L)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x_in       (x_in),
    .signed_mode(signed_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lut_we     (lut_we),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .busy       (busy),
    .y          (y),
    .y_valid    (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint y_now();
    return longint'($signed(y));
  endfunction

  // Reference: y = sum c_k * x_k with x_k read as unsigned or two's complement.
  function automatic longint sop_ref(input int c[N], input logic [B-1:0] x[N], input bit mode);
    longint s;
    longint xv;
    s = 0;
    for (int k = 0; k < N; k++) begin
      if (mode) xv = longint'($signed(x[k]));
      else      xv = longint'(x[k]);
      s += longint'(c[k]) * xv;
    end
    return s;
  endfunction

  task automatic load_table(input int c[N]);
    int s;
    for (int a = 0; a < (1 << N); a++) begin
      s = 0;
      for (int k = 0; k < N; k++) if (a[k]) s += c[k];
      lut_we   = 1'b1;
      lut_addr = N'(a);
      lut_data = L'(s);
      tick;
    end
    lut_we = 1'b0;
  endtask

  task automatic drive_x(input logic [B-1:0] x[N]);
    for (int k = 0; k < N; k++) x_in[k*B +: B] = x[k];
  endtask

  // poke: 0 = none, -1 = write entry F<=0 with the handshake, >0 = write it that many cycles into SHIFT.
  task automatic run_txn(input string tag, input logic [B-1:0] x[N], input bit mode,
                         input longint exp, input int poke);
    int cnt;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick; guard++; end
    if (guard >= 50) chk({tag, "_ready_timeout"}, 0, 1);
    drive_x(x);
    signed_mode = mode;
    in_valid    = 1'b1;
    if (poke == -1) begin lut_we = 1'b1; lut_addr = '1; lut_data = '0; end
    tick;
    in_valid = 1'b0;
    lut_we   = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    cnt = 1;
    while (!y_valid && cnt < 40) begin
      if (cnt == poke) begin lut_we = 1'b1; lut_addr = '1; lut_data = '0; end
      tick;
      lut_we = 1'b0;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, B + 1);
    chk({tag, "_y"}, y_now(), exp);
    $display("txn %s mode=%0d x=%h y=%0d exp=%0d", tag, mode, x_in, y_now(), exp);
    tick;
    chk({tag, "_strobe_len"}, y_valid, 0);
  endtask

  initial begin
    int c[N];
    int c_base[N];
    logic [B-1:0] x[N];
    logic [B-1:0] xs[3][N];
    bit modes[3];
    longint exp_q[$];
    int cyc, last_hs, k, got, bad, seen;
    bit hs;

    reset_n = 1'b0; x_in = '0; signed_mode = 1'b0; in_valid = 1'b0;
    lut_we = 1'b0; lut_addr = '0; lut_data = '0;
    tick; tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_y", y_now(), 0);
    chk("rst_y_valid", y_valid, 0);
    reset_n = 1'b1;
    tick;

    c_base = '{1, 2, 3, 4};
    load_table(c_base);
    x = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_txn("ones", x, 1'b0, sop_ref(c_base, x, 1'b0), 0);
    x = '{8'h80, 8'd0, 8'd0, 8'd0};
    run_txn("x0_unsigned", x, 1'b0, sop_ref(c_base, x, 1'b0), 0);
    run_txn("x0_signed", x, 1'b1, sop_ref(c_base, x, 1'b1), 0);

    c = '{127, 127, 127, 127};
    load_table(c);
    x = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn("max_unsigned", x, 1'b0, sop_ref(c, x, 1'b0), 0);
    c = '{-128, -128, -128, -128};
    load_table(c);
    x = '{8'h80, 8'h80, 8'h80, 8'h80};
    run_txn("min_signed", x, 1'b1, sop_ref(c, x, 1'b1), 0);

    // Write during SHIFT is dropped; write alongside the handshake is seen (entry F becomes 0).
    load_table(c_base);
    x = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_txn("we_in_shift", x, 1'b0, 10, 3);
    run_txn("we_with_hs", x, 1'b0, 0, -1);

    for (int t = 0; t < 20; t++) begin
      bit m;
      for (int j = 0; j < N; j++) begin
        c[j] = int'($urandom_range(255)) - 128;
        x[j] = B'($urandom);
      end
      m = 1'($urandom);
      load_table(c);
      run_txn($sformatf("rand%0d", t), x, m, sop_ref(c, x, m), 0);
    end

    // Back-to-back with in_valid held high.
    c = '{5, -7, 11, -13};
    load_table(c);
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < N; j++) xs[t][j] = B'($urandom);
      modes[t] = 1'($urandom);
    end
    k = 0; got = 0; cyc = 0; last_hs = -1; bad = 0;
    drive_x(xs[0]); signed_mode = modes[0]; in_valid = 1'b1;
    while (got < 3 && cyc < 100) begin
      hs = in_valid && in_ready;
      if (busy == in_ready) bad++;
      tick;
      cyc++;
      if (hs) begin
        exp_q.push_back(sop_ref(c, xs[k], modes[k]));
        if (last_hs >= 0) chk("b2b_interval", cyc - last_hs, B + 2);
        last_hs = cyc;
        k++;
        if (k < 3) begin drive_x(xs[k]); signed_mode = modes[k]; end
        else in_valid = 1'b0;
      end
      if (y_valid) begin
        if (exp_q.size() > 0) begin
          $display("txn b2b%0d y=%0d exp=%0d", got, y_now(), exp_q[0]);
          chk("b2b_y", y_now(), exp_q.pop_front());
        end else chk("b2b_unexpected_y_valid", 1, 0);
        got++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", got, 3);
    chk("b2b_ready_vs_busy", bad, 0);
    tick;

    // Reset mid-SHIFT discards the transaction and clears the table.
    load_table(c_base);
    x = '{8'd1, 8'd1, 8'd1, 8'd1};
    drive_x(x); signed_mode = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_y", y_now(), 0);
    chk("midrst_y_valid", y_valid, 0);
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      tick;
      if (y_valid) seen++;
    end
    chk("midrst_no_strobe", seen, 0);
    run_txn("after_rst", x, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
